// File: rtl/irq_pkg.sv
// Purpose: shared constants, FSM state encoding and index decode helper for the IRQ front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

    localparam int N  = 8;   // request lines, fixed to match the external 8:3 encoder
    localparam int IW = 3;   // index width, log2(N)

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // One-hot decode of an index, used to clear the serviced pending bit.
    function automatic logic [N-1:0] idx_to_onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Purpose: bundles request inputs, encoder loop (y/q), status and the index offer handshake.
// Latency: n/a (wires only).
// Backpressure: irq_valid/irq_ready; the offer holds until irq_ready is seen.
// Ports: master = controller side (drives y, pending, irq_valid, irq_index),
//        slave  = environment side (drives irq_in, mask, q, irq_ready).
interface irq_pending_ctrl_if;
    import irq_pkg::*;

    logic [N-1:0]  irq_in;
    logic [N-1:0]  mask;
    logic [N-1:0]  y;
    logic [IW-1:0] q;
    logic          irq_valid;
    logic [IW-1:0] irq_index;
    logic          irq_ready;
    logic [N-1:0]  pending;

    modport master (
        input  irq_in, mask, q, irq_ready,
        output y, irq_valid, irq_index, pending
    );

    modport slave (
        output irq_in, mask, q, irq_ready,
        input  y, irq_valid, irq_index, pending
    );

endinterface

// File: rtl/irq_sync_edge.sv
// Purpose: per-line SYNC_STAGES synchronizer, history flop and rising-edge pulse.
// Latency: input high before edge k gives rise=1 between edges k+SYNC_STAGES-1 and k+SYNC_STAGES.
// Backpressure: none; pulses are one cycle wide and must be captured by the consumer.
// Ports: clk, rst_n; d = raw async lines; rise = one-cycle pulse per synchronized 0->1 transition.
module irq_sync_edge #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2   // must be >= 2 for metastability settling
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] rise
);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A level held high yields a single pulse: once hist catches up, rise drops.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Purpose: latch synchronized IRQ edges into pending, feed pending&mask to the encoder, offer its index.
// Latency: irq_in high before edge k -> pending at k+2 -> irq_valid/irq_index at k+3.
// Backpressure: offer (index frozen) held until irq_ready; one IDLE cycle between offers.
// Ports: clk, rst_n (async active-low); bus = irq_pending_ctrl_if.master
//        (irq_in, mask, q in; y, pending, irq_valid, irq_index out; irq_ready in).
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_pending_ctrl_if.master   bus
);

    logic [N-1:0]  rise;
    logic [N-1:0]  pending_q;
    logic [N-1:0]  pending_d;
    logic [N-1:0]  clr_vec;
    logic [IW-1:0] index_q;
    state_t        state_q;
    state_t        state_d;
    logic          load_index;
    logic          accept;

    irq_sync_edge #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.irq_in),
        .rise  (rise)
    );

    // Next state. Loading only from IDLE guarantees a settling cycle for y/q
    // after a clear, and freezes the index for the whole offer.
    always_comb begin
        state_d    = state_q;
        load_index = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.y) begin
                    load_index = 1'b1;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (bus.irq_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear is applied before OR-ing in new edges, so a same-cycle edge on
    // the serviced line survives as a fresh request.
    assign clr_vec   = accept ? idx_to_onehot(index_q) : '0;
    assign pending_d = (pending_q & ~clr_vec) | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (load_index) begin
                index_q <= bus.q;
            end
        end
    end

    assign bus.y         = pending_q & bus.mask;
    assign bus.pending   = pending_q;
    assign bus.irq_valid = (state_q == OFFER);
    assign bus.irq_index = index_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;
    import irq_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_q[$];

    irq_pending_ctrl_if ifc ();

    irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    // External 8:3 encoder model: index of the highest set bit of y.
    always_comb begin
        ifc.q = '0;
        for (int i = 0; i < N; i++) begin
            if (ifc.y[i]) ifc.q = 3'(i);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus utilities (no comparisons inside).
    task automatic do_reset();
        rst_n         = 1'b0;
        ifc.irq_in    = '0;
        ifc.mask      = '0;
        ifc.irq_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_irq(input logic [N-1:0] bits);
        ifc.irq_in = ifc.irq_in | bits;
        @(negedge clk);
        ifc.irq_in = ifc.irq_in & ~bits;
    endtask

    task automatic wait_valid(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (ifc.irq_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept_one();
        ifc.irq_ready = 1'b1;
        @(negedge clk);
        ifc.irq_ready = 1'b0;
    endtask

    task automatic test_reset();
        int exp;
        rst_n         = 1'b0;
        ifc.irq_in    = 8'hFF;
        ifc.mask      = 8'hFF;
        ifc.irq_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ifc.pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h want 00", ifc.pending); end
        n_checks++;
        if (ifc.y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h want 00", ifc.y); end
        n_checks++;
        if (ifc.irq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ifc.irq_valid); end

        exp_q.push_back(7);
        rst_n = 1'b1;
        @(negedge clk);   // after edge k
        @(negedge clk);   // after edge k+1
        n_checks++;
        if (ifc.pending !== 8'h00) begin n_fail++; $display("FAIL rel_pending_k1: got %h want 00", ifc.pending); end
        @(negedge clk);   // after edge k+2
        n_checks++;
        if (ifc.pending !== 8'hFF) begin n_fail++; $display("FAIL rel_pending_k2: got %h want ff", ifc.pending); end
        n_checks++;
        if (ifc.irq_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid_k2: got %b want 0", ifc.irq_valid); end
        @(negedge clk);   // after edge k+3
        n_checks++;
        if (ifc.irq_valid !== 1'b1) begin
            n_fail++; $display("FAIL rel_valid_k3: got %b want 1", ifc.irq_valid);
        end else begin
            exp = exp_q.pop_front();
            n_checks++;
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL rel_index_k3: got %0d want %0d", ifc.irq_index, exp); end
        end

        // Drain with irq_in still held high: each line requests only once.
        exp_q.delete();
        for (int i = 6; i >= 0; i--) exp_q.push_back(i);
        ifc.irq_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (ifc.irq_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL level_extra_offer: got index %0d want none", ifc.irq_index);
                end else begin
                    exp = exp_q.pop_front();
                    if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL level_drain_index: got %0d want %0d", ifc.irq_index, exp); end
                end
            end
        end
        ifc.irq_ready = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL level_missing: got %0d left want 0", exp_q.size()); end
        n_checks++;
        if (ifc.pending !== 8'h00) begin n_fail++; $display("FAIL level_pending: got %h want 00", ifc.pending); end
    endtask

    task automatic test_priority_drain();
        int exp;
        int cyc;
        int last;
        do_reset();
        pulse_irq(8'b1101_1101);
        repeat (4) @(negedge clk);
        n_checks++;
        if (ifc.pending !== 8'b1101_1101) begin n_fail++; $display("FAIL drain_load: got %b want 11011101", ifc.pending); end
        n_checks++;
        if (ifc.irq_valid !== 1'b0) begin n_fail++; $display("FAIL drain_masked_valid: got %b want 0", ifc.irq_valid); end

        exp_q.delete();
        exp_q.push_back(7); exp_q.push_back(6); exp_q.push_back(4);
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(0);
        ifc.mask      = 8'hFF;
        ifc.irq_ready = 1'b1;
        cyc  = 0;
        last = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cyc++;
            if (ifc.irq_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL drain_extra_offer: got index %0d want none", ifc.irq_index);
                end else begin
                    exp = exp_q.pop_front();
                    if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL drain_index: got %0d want %0d", ifc.irq_index, exp); end
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 2) begin n_fail++; $display("FAIL drain_spacing: got %0d cycles want 2", cyc - last); end
                end
                last = cyc;
            end
        end
        ifc.irq_ready = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_missing: got %0d left want 0", exp_q.size()); end
        n_checks++;
        if (ifc.pending !== 8'h00) begin n_fail++; $display("FAIL drain_pending: got %h want 00", ifc.pending); end
        n_checks++;
        if (ifc.irq_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end: got %b want 0", ifc.irq_valid); end
    endtask

    task automatic test_masking();
        bit seen;
        bit any;
        int exp;
        do_reset();
        ifc.mask = 8'b0000_0010;
        exp_q.delete();
        exp_q.push_back(1);
        pulse_irq(8'b0010_0010);
        wait_valid(10, seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL mask_offer1_timeout: got no offer want index 1");
        end else begin
            exp = exp_q.pop_front();
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL mask_offer1: got %0d want %0d", ifc.irq_index, exp); end
        end
        accept_one();
        n_checks++;
        if (ifc.pending !== 8'b0010_0000) begin n_fail++; $display("FAIL mask_pending_left: got %b want 00100000", ifc.pending); end
        any = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ifc.irq_valid) any = 1'b1;
        end
        n_checks++;
        if (any) begin n_fail++; $display("FAIL mask_blocked: got offer want none"); end

        exp_q.push_back(5);
        ifc.mask = 8'hFF;
        wait_valid(5, seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL mask_offer5_timeout: got no offer want index 5");
        end else begin
            exp = exp_q.pop_front();
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL mask_offer5: got %0d want %0d", ifc.irq_index, exp); end
        end
        accept_one();
    endtask

    task automatic test_backpressure();
        bit seen;
        bit stable;
        int exp;
        do_reset();
        ifc.mask = 8'hFF;
        exp_q.delete();
        exp_q.push_back(2);
        pulse_irq(8'h04);
        wait_valid(10, seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL bp_offer_timeout: got no offer want index 2");
        end else begin
            exp = exp_q.pop_front();
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL bp_offer: got %0d want %0d", ifc.irq_index, exp); end
        end
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ifc.irq_valid !== 1'b1 || ifc.irq_index !== 3'd2) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL bp_hold: got valid %b index %0d want 1/2", ifc.irq_valid, ifc.irq_index); end

        exp_q.push_back(7);
        pulse_irq(8'h80);
        repeat (5) @(negedge clk);
        n_checks++;
        if (ifc.irq_index !== 3'd2 || ifc.irq_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_no_preempt: got valid %b index %0d want 1/2", ifc.irq_valid, ifc.irq_index);
        end
        n_checks++;
        if (ifc.pending !== 8'h84) begin n_fail++; $display("FAIL bp_pending: got %h want 84", ifc.pending); end
        accept_one();
        n_checks++;
        if (ifc.irq_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_gap: got %b want 0", ifc.irq_valid); end
        wait_valid(3, seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL bp_next_timeout: got no offer want index 7");
        end else begin
            exp = exp_q.pop_front();
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL bp_next: got %0d want %0d", ifc.irq_index, exp); end
        end
        accept_one();
    endtask

    task automatic test_collision();
        bit seen;
        int exp;
        do_reset();
        ifc.mask = 8'hFF;
        exp_q.delete();
        exp_q.push_back(3);
        pulse_irq(8'h08);
        wait_valid(10, seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL coll_offer_timeout: got no offer want index 3");
        end else begin
            exp = exp_q.pop_front();
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL coll_offer: got %0d want %0d", ifc.irq_index, exp); end
        end
        // New edge on bit 3: s1 captures at edge X, pulse detected for edge X+2,
        // which is also the accept edge.
        exp_q.push_back(3);
        ifc.irq_in[3] = 1'b1;
        @(negedge clk);
        ifc.irq_in[3] = 1'b0;
        @(negedge clk);
        ifc.irq_ready = 1'b1;
        @(negedge clk);
        ifc.irq_ready = 1'b0;
        n_checks++;
        if (ifc.irq_valid !== 1'b0) begin n_fail++; $display("FAIL coll_accepted: got valid %b want 0", ifc.irq_valid); end
        n_checks++;
        if (ifc.pending !== 8'h08) begin n_fail++; $display("FAIL coll_set_wins: got %h want 08", ifc.pending); end
        wait_valid(3, seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL coll_reoffer_timeout: got no offer want index 3");
        end else begin
            exp = exp_q.pop_front();
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL coll_reoffer: got %0d want %0d", ifc.irq_index, exp); end
        end
        accept_one();
    endtask

    task automatic test_reset_mid_offer();
        bit seen;
        bit any;
        int exp;
        do_reset();
        ifc.mask = 8'hFF;
        exp_q.delete();
        exp_q.push_back(6);
        pulse_irq(8'h40);
        wait_valid(10, seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rmo_offer_timeout: got no offer want index 6");
        end else begin
            exp = exp_q.pop_front();
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL rmo_offer: got %0d want %0d", ifc.irq_index, exp); end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ifc.irq_valid !== 1'b0) begin n_fail++; $display("FAIL rmo_valid_async: got %b want 0", ifc.irq_valid); end
        n_checks++;
        if (ifc.pending !== 8'h00) begin n_fail++; $display("FAIL rmo_pending_async: got %h want 00", ifc.pending); end
        @(negedge clk);
        rst_n = 1'b1;
        any = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ifc.irq_valid) any = 1'b1;
        end
        n_checks++;
        if (any) begin n_fail++; $display("FAIL rmo_spurious: got offer want none"); end
        exp_q.push_back(1);
        pulse_irq(8'h02);
        wait_valid(10, seen);
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rmo_new_timeout: got no offer want index 1");
        end else begin
            exp = exp_q.pop_front();
            if (ifc.irq_index !== 3'(exp)) begin n_fail++; $display("FAIL rmo_new: got %0d want %0d", ifc.irq_index, exp); end
        end
        accept_one();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_priority_drain();
        test_masking();
        test_backpressure();
        test_collision();
        test_reset_mid_offer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Interrupt-request front end that feeds the 8:3 priority encoder. It synchronizes 8 raw request lines, edge-detects them and latches them into a pending register.
- It drives the masked pending vector `y` to the encoder and reads back the encoded index `q`.
- It offers the winning index to a downstream consumer over a valid/ready handshake, and clears the serviced pending bit on acceptance.

Parameters:
- N, 8, number of request lines (fixed at 8 to match encoder).
- IW, 3, index width (log2 N).
- SYNC_STAGES, 2, synchronizer flops per request line (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- irq_in  in  8  raw asynchronous request lines; a rising edge raises a request.
- mask  in  8  per-line enable; 1 = line may be offered.
- y  out  8  pending & mask, wired to encoder input.
- q  in  3  encoder output (index of highest set bit of y).
- irq_valid  out  1  index offer valid.
- irq_index  out  3  offered index, registered.
- irq_ready  in  1  consumer accepts offer.
- pending  out  8  raw pending register (unmasked), for status.

Behaviour:
- Clock and reset: one clock, clk. rst_n asynchronous active-low. While rst_n=0, all of the following are 0:
  - synchronizer flops and edge-history flops
  - pending, irq_valid, irq_index
  - FSM state (IDLE)
- Synchronization: each irq_in bit passes through SYNC_STAGES flops, then one history flop. edge[i] = sync_out[i] & ~hist[i].
- Pending set latency: irq_in[i] high before rising edge k (SYNC_STAGES=2) sets pending[i] at edge k+2.
- Output y: combinational, y = pending & mask. No register between pending and y.
- Encoder convention: q = index of highest set bit of y. q is ignored when y==0.
- FSM state IDLE:
  - irq_valid=0.
  - If |y at a rising edge: irq_index <= q, irq_valid <= 1, go to OFFER.
  - irq_valid therefore rises at edge k+3 after the request.
- FSM state OFFER:
  - irq_valid=1.
  - irq_index holds stable until accepted. Pending, mask and y changes do not alter it, even if a higher-priority line arrives.
  - On irq_valid & irq_ready: clear pending[irq_index], irq_valid <= 0, go to IDLE.
- Minimum spacing: one IDLE cycle is mandatory between offers, so y/q settle after the clear. Max throughput is one offer per 2 cycles.
- Simultaneous set and clear on the same bit in one cycle: set wins, and the bit stays pending. The new edge is a new request.
- Level-held request: a line held high generates only one request. It must return low, then high again, to re-request.
- Masked lines: they still latch into pending but never appear in y. Unmasking later makes them eligible.
- Mask cleared on the offered line during OFFER: the offer is still completed. The consumer may accept it, and the bit is cleared on accept.
- irq_ready while irq_valid=0: ignored, no state change.
- Reset mid-offer: irq_valid drops immediately (asynchronous) and all pending requests are lost.
- Out-of-range index: not possible (IW=3, N=8). No wrap handling required.

Decomposition:
- Shared package irq_pkg holds:
  - N=8 and IW=3 constants
  - state encoding IDLE=1'b0, OFFER=1'b1
- Sub-module irq_sync_edge: SYNC_STAGES synchronizer plus history flop plus rising-edge pulse, vectorized over N.
- The 8:3 priority encoder stays external. The top level connects y->encoder->q.

Test Plan:
- Reset: rst_n=0 with irq_in=8'hFF -> pending=0, y=0, irq_valid=0. Release, then hold irq_in=8'hFF, mask=8'hFF -> pending=8'hFF at edge +2, irq_valid=1 with irq_index=7 at edge +3.
- Priority drain: pending=8'b11011101, mask=8'hFF, irq_ready tied 1 -> indices offered in order 7,6,4,3,2,0, one every 2 cycles. pending=0 afterwards, irq_valid stays 0.
- Masking: irq_in pulses on bits 5 and 1, mask=8'b00000010 -> only index 1 offered, pending=8'b00100000 remains. Setting mask=8'hFF -> index 5 offered next.
- Hold under backpressure: offer index 2 with irq_ready=0 for 10 cycles, then raise irq_in[7] -> irq_index stays 2. After accept, index 7 is offered on the next offer.
- Set/clear collision: accept index 3 in the same cycle that the edge on bit 3 is detected -> pending[3] remains 1, and index 3 is re-offered.
- Reset mid-offer: irq_valid=1 with index 6, assert rst_n=0 asynchronously between clock edges -> irq_valid=0 and pending=0 immediately. No offer after release until a new irq_in edge.
